// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory with debug dump engine.
//   SZ_*           access size codes on the size port
//   dump_state_t   dump FSM state encodings
//   nb_of          bytes per word
//   off_bits       byte-offset width inside a word (0 when a word is one byte)
//   lane_bits      off_bits clamped to at least 1, for declaring offset buses
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

    function automatic int nb_of(input int dw);
        return dw / 8;
    endfunction

    function automatic int off_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int lane_bits(input int dw);
        int lb;
        lb = $clog2(dw / 8);
        return (lb > 0) ? lb : 1;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory.
//   Store side: acc_size/acc_off/wdata -> aligned, st_be (byte enables), st_data (data moved to lane)
//   Load side : ld_word/ld_size/ld_off/ld_sign -> ld_data (lane extracted, sign/zero extended)
// Bytes are little-endian inside a word: byte offset k lives in bits [8k+7:8k].
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]                       acc_size,
    input  logic [lane_bits(DATA_WIDTH)-1:0] acc_off,
    input  logic [DATA_WIDTH-1:0]            wdata,
    output logic                             aligned,
    output logic [DATA_WIDTH/8-1:0]          st_be,
    output logic [DATA_WIDTH-1:0]            st_data,
    input  logic [DATA_WIDTH-1:0]            ld_word,
    input  logic [1:0]                       ld_size,
    input  logic [lane_bits(DATA_WIDTH)-1:0] ld_off,
    input  logic                             ld_sign,
    output logic [DATA_WIDTH-1:0]            ld_data
);

    localparam int NB  = nb_of(DATA_WIDTH);
    localparam int LBW = lane_bits(DATA_WIDTH);

    logic [LBW+2:0]          st_shamt;
    logic [LBW+2:0]          ld_shamt;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [15:0]             half_raw;
    logic [DATA_WIDTH-1:0]   byte_ext;
    logic [DATA_WIDTH-1:0]   half_ext;

    assign st_shamt = {acc_off, 3'b000};
    assign ld_shamt = {ld_off, 3'b000};

    // Reserved size 2'b11 is treated as misaligned so the access is dropped.
    always_comb begin
        aligned = 1'b0;
        case (acc_size)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = (NB >= 2) && !acc_off[0];
            SZ_WORD: aligned = (acc_off == '0);
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        st_be = '0;
        case (acc_size)
            SZ_BYTE: st_be = NB'(1) << acc_off;
            SZ_HALF: st_be = NB'(3) << acc_off;
            SZ_WORD: st_be = '1;
            default: st_be = '0;
        endcase
    end

    // Right-justified store data is moved up to the addressed lane; only
    // enabled lanes are written, so the other bytes are don't-care.
    assign st_data = wdata << st_shamt;

    assign shifted = ld_word >> ld_shamt;

    generate
        if (DATA_WIDTH >= 16) begin : g_half_wide
            assign half_raw = shifted[15:0];
        end else begin : g_half_narrow
            assign half_raw = {8'h00, shifted[7:0]};
        end
    endgenerate

    always_comb begin
        byte_ext = DATA_WIDTH'(shifted[7:0]);
        if (ld_sign && shifted[7]) begin
            byte_ext = byte_ext | ~DATA_WIDTH'(8'hFF);
        end
        half_ext = DATA_WIDTH'(half_raw);
        if (ld_sign && half_raw[15]) begin
            half_ext = half_ext | ~DATA_WIDTH'(16'hFFFF);
        end
        case (ld_size)
            SZ_BYTE: ld_data = byte_ext;
            SZ_HALF: ld_data = half_ext;
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/data_memory_dump.sv
// Data memory for the CPU MEM stage with a post-halt debug dump engine.
//   CPU port : en, write, size, sign_ext, addr, wdata -> rdata, rvalid, misaligned (1-cycle latency)
//   Stall    : busy is high while a dump runs; CPU accesses are ignored then
//   Dump port: dump_start -> dump_valid/dump_addr/dump_data with dump_ready handshake, dump_done pulse
// Array contents are undefined until written.
// The array is split into one byte-wide memory per lane so byte enables map
// directly onto independent RAMs, each with registered read ports.
module data_memory_dump
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10,
    parameter     INIT_FILE  = ""
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      en,
    input  logic                                      write,
    input  logic [1:0]                                size,
    input  logic                                      sign_ext,
    input  logic [ADDR_BITS-1:0]                      addr,
    input  logic [DATA_WIDTH-1:0]                     wdata,
    output logic [DATA_WIDTH-1:0]                     rdata,
    output logic                                      rvalid,
    output logic                                      misaligned,
    output logic                                      busy,
    input  logic                                      dump_start,
    output logic                                      dump_valid,
    input  logic                                      dump_ready,
    output logic [ADDR_BITS-off_bits(DATA_WIDTH)-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0]                     dump_data,
    output logic                                      dump_done
);

    localparam int NB    = nb_of(DATA_WIDTH);
    localparam int LB    = off_bits(DATA_WIDTH);
    localparam int LBW   = lane_bits(DATA_WIDTH);
    localparam int WAW   = ADDR_BITS - LB;
    localparam int DEPTH = 2 ** WAW;

    dump_state_t           state_reg;
    logic                  busy_reg;
    logic                  rvalid_reg;
    logic                  misaligned_reg;
    logic                  dump_valid_reg;
    logic                  dump_done_reg;
    logic [WAW-1:0]        dump_addr_reg;
    logic [1:0]            ld_size_reg;
    logic [LBW-1:0]        ld_off_reg;
    logic                  ld_sign_reg;

    logic [WAW-1:0]        word_idx;
    logic [LBW-1:0]        acc_off;
    logic                  aligned;
    logic [NB-1:0]         st_be;
    logic [DATA_WIDTH-1:0] st_data;
    logic [DATA_WIDTH-1:0] cpu_word;
    logic [DATA_WIDTH-1:0] dump_word;
    logic                  access_ok;
    logic                  wr_en;
    logic                  ld_en;

    assign word_idx = addr[ADDR_BITS-1:LB];

    generate
        if (LB > 0) begin : g_off
            assign acc_off = addr[LB-1:0];
        end else begin : g_no_off
            assign acc_off = '0;
        end
    endgenerate

    // CPU accesses are only honoured while the dump engine is idle.
    assign access_ok = en && (state_reg == ST_IDLE);
    assign wr_en     = access_ok && write && aligned;
    assign ld_en     = access_ok && !write && aligned;

    dmem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .acc_size (size),
        .acc_off  (acc_off),
        .wdata    (wdata),
        .aligned  (aligned),
        .st_be    (st_be),
        .st_data  (st_data),
        .ld_word  (cpu_word),
        .ld_size  (ld_size_reg),
        .ld_off   (ld_off_reg),
        .ld_sign  (ld_sign_reg),
        .ld_data  (rdata)
    );

    // One byte RAM per lane. The CPU read register only moves on a load, so
    // rdata holds until the next load; the dump read register moves in READ.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] cpu_byte_reg;
            logic [7:0] dump_byte_reg;

            always_ff @(posedge clk) begin
                if (wr_en && st_be[gi]) begin
                    mem[word_idx] <= st_data[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cpu_byte_reg  <= 8'h00;
                    dump_byte_reg <= 8'h00;
                end else begin
                    if (ld_en) begin
                        cpu_byte_reg <= mem[word_idx];
                    end
                    if (state_reg == ST_READ) begin
                        dump_byte_reg <= mem[dump_addr_reg];
                    end
                end
            end

            assign cpu_word[gi*8 +: 8]  = cpu_byte_reg;
            assign dump_word[gi*8 +: 8] = dump_byte_reg;
        end
    endgenerate

    // Access result pulses and the dump FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            rvalid_reg     <= 1'b0;
            misaligned_reg <= 1'b0;
            dump_valid_reg <= 1'b0;
            dump_done_reg  <= 1'b0;
            dump_addr_reg  <= '0;
            ld_size_reg    <= SZ_BYTE;
            ld_off_reg     <= '0;
            ld_sign_reg    <= 1'b0;
        end else begin
            rvalid_reg     <= 1'b0;
            misaligned_reg <= 1'b0;
            dump_done_reg  <= 1'b0;

            if (access_ok) begin
                if (!aligned) begin
                    misaligned_reg <= 1'b1;
                end else if (!write) begin
                    rvalid_reg  <= 1'b1;
                    ld_size_reg <= size;
                    ld_off_reg  <= acc_off;
                    ld_sign_reg <= sign_ext;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (dump_start) begin
                        state_reg <= ST_READ;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_READ: begin
                    state_reg      <= ST_SEND;
                    dump_valid_reg <= 1'b1;
                end
                ST_SEND: begin
                    if (dump_ready) begin
                        dump_valid_reg <= 1'b0;
                        if (&dump_addr_reg) begin
                            state_reg     <= ST_DONE;
                            dump_done_reg <= 1'b1;
                            dump_addr_reg <= '0;
                        end else begin
                            state_reg     <= ST_READ;
                            dump_addr_reg <= dump_addr_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rvalid     = rvalid_reg;
    assign misaligned = misaligned_reg;
    assign busy       = busy_reg;
    assign dump_valid = dump_valid_reg;
    assign dump_addr  = dump_addr_reg;
    assign dump_data  = dump_word;
    assign dump_done  = dump_done_reg;

endmodule

// File: tb/tb_data_memory_dump.sv
module tb_data_memory_dump;

    localparam int DW    = 32;
    localparam int AB    = 8;
    localparam int WAW   = 6;
    localparam int DEPTH = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           write = 1'b0;
    logic [1:0]     size = 2'b00;
    logic           sign_ext = 1'b0;
    logic [AB-1:0]  addr = '0;
    logic [DW-1:0]  wdata = '0;
    logic [DW-1:0]  rdata;
    logic           rvalid;
    logic           misaligned;
    logic           busy;
    logic           dump_start = 1'b0;
    logic           dump_valid;
    logic           dump_ready = 1'b0;
    logic [WAW-1:0] dump_addr;
    logic [DW-1:0]  dump_data;
    logic           dump_done;

    always #5 clk = ~clk;

    data_memory_dump #(
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AB),
        .INIT_FILE  ("")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .write      (write),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .misaligned (misaligned),
        .busy       (busy),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain byte-addressed memory, little-endian words.
    logic [7:0] model_mem [256];

    typedef struct {
        bit          mis;
        logic [31:0] data;
        logic [7:0]  a;
    } cpu_exp_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } dump_exp_t;

    cpu_exp_t  cpu_q[$];
    dump_exp_t dump_q[$];
    logic [31:0] held_rdata = '0;
    int          done_count = 0;

    bit             stall_prev = 1'b0;
    logic [WAW-1:0] stall_addr;
    logic [31:0]    stall_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_aligned(input logic [1:0] s, input logic [7:0] a);
        case (s)
            2'd0:    return 1'b1;
            2'd1:    return (a % 2) == 0;
            2'd2:    return (a % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] s, input bit sg, input logic [7:0] a);
        logic [31:0] v;
        case (s)
            2'd0: begin
                v = {24'h0, model_mem[a]};
                if (sg && v[7]) v[31:8] = '1;
            end
            2'd1: begin
                v = {16'h0, model_mem[a + 8'd1], model_mem[a]};
                if (sg && v[15]) v[31:16] = '1;
            end
            default: v = {model_mem[a + 8'd3], model_mem[a + 8'd2], model_mem[a + 8'd1], model_mem[a]};
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_word(input int i);
        return {model_mem[4*i+3], model_mem[4*i+2], model_mem[4*i+1], model_mem[4*i]};
    endfunction

    task automatic model_store(input logic [1:0] s, input logic [7:0] a, input logic [31:0] d);
        model_mem[a] = d[7:0];
        if (s >= 2'd1) model_mem[a + 8'd1] = d[15:8];
        if (s == 2'd2) begin
            model_mem[a + 8'd2] = d[23:16];
            model_mem[a + 8'd3] = d[31:24];
        end
    endtask

    // One CPU access while idle; expectation is queued before the edge.
    task automatic access(input bit w, input logic [1:0] s, input bit sg,
                          input logic [7:0] a, input logic [31:0] d);
        cpu_exp_t e;
        en = 1'b1; write = w; size = s; sign_ext = sg; addr = a; wdata = d;
        if (!is_aligned(s, a)) begin
            e = '{1'b1, 32'h0, a};
            cpu_q.push_back(e);
        end else if (w) begin
            model_store(s, a, d);
        end else begin
            e = '{1'b0, model_load(s, sg, a), a};
            cpu_q.push_back(e);
        end
        @(posedge clk); #1;
        en = 1'b0; write = 1'b0;
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        cpu_exp_t  ce;
        dump_exp_t de;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (rvalid || misaligned) begin
                if (cpu_q.size() == 0) begin
                    check("unexpected_cpu_pulse", {30'h0, rvalid, misaligned}, 32'h0);
                end else begin
                    ce = cpu_q.pop_front();
                    check("cpu_pulse_kind", {30'h0, rvalid, misaligned}, ce.mis ? 32'd1 : 32'd2);
                    if (!ce.mis) begin
                        check("load_rdata", rdata, ce.data);
                        held_rdata = ce.data;
                        $display("load       addr=%h rdata=%h exp=%h", ce.a, rdata, ce.data);
                    end else begin
                        $display("misaligned addr=%h", ce.a);
                    end
                end
            end
            if (!rvalid) check("rdata_hold", rdata, held_rdata);

            if (stall_prev) begin
                check("stall_valid", {31'h0, dump_valid}, 32'd1);
                check("stall_addr", {26'h0, dump_addr}, {26'h0, stall_addr});
                check("stall_data", dump_data, stall_data);
            end
            stall_prev = 1'b0;
            if (dump_valid) begin
                if (dump_ready) begin
                    if (dump_q.size() == 0) begin
                        check("unexpected_dump_word", 32'd1, 32'd0);
                    end else begin
                        de = dump_q.pop_front();
                        check("dump_addr", {26'h0, dump_addr}, de.idx);
                        check("dump_data", dump_data, de.data);
                        $display("dump       word=%0d data=%h exp=%h", dump_addr, dump_data, de.data);
                    end
                end else begin
                    stall_prev = 1'b1;
                    stall_addr = dump_addr;
                    stall_data = dump_data;
                end
            end
            if (dump_done) begin
                done_count++;
                check("done_words_left", dump_q.size(), 32'd0);
            end
        end
    end

    task automatic push_dump_all();
        dump_exp_t de;
        for (int i = 0; i < DEPTH; i++) begin
            de = '{i, model_word(i)};
            dump_q.push_back(de);
        end
    endtask

    // mode 0: dump_ready held high; mode 1: random ready plus a 5-cycle stall.
    task automatic run_dump(input int mode, input bit with_store);
        int cycles;
        int d0;
        int bound;
        logic [7:0]  sa;
        logic [31:0] sd;
        d0 = done_count;
        dump_start = 1'b1;
        dump_ready = (mode == 0);
        if (with_store) begin
            sa = 8'($urandom_range(0, DEPTH-1) * 4);
            sd = $urandom;
            en = 1'b1; write = 1'b1; size = 2'd2; addr = sa; wdata = sd;
            model_store(2'd2, sa, sd);
        end
        push_dump_all();
        @(posedge clk); #1;
        dump_start = 1'b0; en = 1'b0; write = 1'b0;
        cycles = 1;
        bound = (mode == 0) ? 2*DEPTH + 10 : 12*DEPTH;
        while (1) begin
            en = 1'($urandom_range(0, 1));
            write = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            sign_ext = 1'($urandom_range(0, 1));
            addr = 8'($urandom);
            wdata = $urandom;
            dump_start = ($urandom_range(0, 7) == 0);
            if (mode == 0) dump_ready = 1'b1;
            else if (cycles >= 6 && cycles <= 10) dump_ready = 1'b0;
            else dump_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); cycles++; #1;
            check("busy_during_dump", {31'h0, busy}, 32'd1);
            if (dump_done) break;
            if (cycles > bound) begin
                check("dump_timeout", 32'd0, 32'd1);
                break;
            end
        end
        en = 1'b0; write = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        if (mode == 0) check("dump_cycles", cycles, 2*DEPTH + 1);
        @(posedge clk); #1;
        check("busy_after_dump", {31'h0, busy}, 32'd0);
        check("valid_after_dump", {31'h0, dump_valid}, 32'd0);
        check("addr_after_dump", {26'h0, dump_addr}, 32'd0);
        check("dump_done_count", done_count - d0, 32'd1);
        check("dump_queue_empty", dump_q.size(), 32'd0);
        dump_q.delete();
        $display("dump finished mode=%0d cycles=%0d", mode, cycles);
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_rvalid"}, {31'h0, rvalid}, 32'h0);
        check({tag, "_misaligned"}, {31'h0, misaligned}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_dump_valid"}, {31'h0, dump_valid}, 32'h0);
        check({tag, "_dump_addr"}, {26'h0, dump_addr}, 32'h0);
        check({tag, "_dump_data"}, dump_data, 32'h0);
        check({tag, "_dump_done"}, {31'h0, dump_done}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int d0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) access(1'b1, 2'd2, 1'b0, 8'(i*4), $urandom);

        // Directed loads/stores.
        access(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF);
        access(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        access(1'b1, 2'd0, 1'b0, 8'h13, 32'h00000080);
        access(1'b0, 2'd0, 1'b1, 8'h13, 32'h0);
        access(1'b0, 2'd0, 1'b0, 8'h13, 32'h0);
        access(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        access(1'b0, 2'd1, 1'b0, 8'h11, 32'h0);
        access(1'b0, 2'd2, 1'b0, 8'h12, 32'h0);
        access(1'b0, 2'd3, 1'b0, 8'h10, 32'h0);
        access(1'b1, 2'd2, 1'b0, 8'h12, 32'h12345678);
        access(1'b1, 2'd1, 1'b0, 8'h11, 32'h0000AAAA);
        access(1'b1, 2'd3, 1'b0, 8'h10, 32'h55555555);
        access(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        access(1'b0, 2'd1, 1'b1, 8'h12, 32'h0);

        // Randomized back-to-back accesses.
        for (int i = 0; i < 300; i++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   8'($urandom), $urandom);
        end
        repeat (2) @(posedge clk);
        #1;

        run_dump(0, 1'b1);
        run_dump(1, 1'b0);

        // Reset in the middle of a dump, while word 7 is being offered.
        d0 = done_count;
        dump_start = 1'b1;
        push_dump_all();
        @(posedge clk); #1;
        dump_start = 1'b0;
        dump_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (dump_valid && dump_addr == 6'd7) begin
                found = 1;
                break;
            end
        end
        check("reached_word7", found, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_reset("async_reset");
        dump_q.delete();
        held_rdata = '0;
        dump_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_abort", done_count - d0, 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_dump(0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            access(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom), 32'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("cpu_queue_drained", cpu_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
